// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, memory-busy freeze and branch flush
// control for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall_cycles
// performance counter; otherwise stall_cycles is tied to zero.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W         = 4,
  parameter int NUM_SRC            = 2,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int PERF_CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_is_load,
  input  logic                          ex_wb_en,
  input  logic [REG_ADDR_W-1:0]         ex_wb_addr,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          branch_taken,
  input  logic                          mem_busy,
  output logic                          pc_pause,
  output logic                          if_id_pause,
  output logic                          id_exe_pause,
  output logic                          exe_mem_pause,
  output logic                          if_id_flush,
  output logic                          id_exe_flush,
  output logic [PERF_CNT_W-1:0]         stall_cycles
);

  typedef enum logic [0:0] {IDLE, LOAD_STALL} state_t;

  // Counter value loaded when a multi-cycle stall starts; the detection
  // cycle itself is the first stall cycle.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [2:0]            cnt_reg, cnt_next;
  logic [NUM_SRC-1:0]    src_match;
  logic                  dest_ok;
  logic                  hazard;

  // One comparator per ID source operand against the EXE destination.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_match[gi] = id_src_used[gi] &&
                             (id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W] == ex_wb_addr);
    end
    if (ZERO_REG_HARDWIRED != 0) begin : g_zero
      // Writes to the hardwired zero register never produce a value to wait for.
      assign dest_ok = (ex_wb_addr != '0);
    end else begin : g_nozero
      assign dest_ok = 1'b1;
    end
  endgenerate

  assign hazard = ex_is_load && ex_wb_en && dest_ok && (|src_match);

  // State and stall counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and output decode: mem_busy freezes everything, then load stall, then branch flush.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    id_exe_pause  = 1'b0;
    exe_mem_pause = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    if (!rst) begin
      state_next = IDLE;
      cnt_next   = 3'd0;
    end else if (mem_busy) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_exe_pause  = 1'b1;
      exe_mem_pause = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hazard) begin
            pc_pause     = 1'b1;
            if_id_pause  = 1'b1;
            id_exe_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next = LOAD_STALL;
              cnt_next   = STALL_RELOAD;
            end
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          // The load has left EXE, so the hazard input no longer matters here.
          pc_pause     = 1'b1;
          if_id_pause  = 1'b1;
          id_exe_flush = 1'b1;
          cnt_next     = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_reg;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (pc_pause && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = rst ? stall_cnt_reg : '0;
`else
  assign stall_cycles = '0;
`endif

endmodule
